sdf_issue_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency, non-stallable SDF evaluator (e.g. an `SDF_STAGES = 2` primitive such as the infinite-cross SDF) between `NUM_REQ` ray-march units. Each cycle it grants at most one requester and registers that requester's 27-bit float point onto the SDF inputs. It tracks the requester id alongside the SDF pipeline and returns each distance through a credit-protected result FIFO with valid/ready handshake. It sits between the per-ray march FSMs and the SDF datapath in the raymarching core.

---
 rtl/raymarch_pkg.sv | 10 +
 rtl/sdf_result_fifo.sv | 39 +++
 rtl/sdf_issue_arbiter.sv | 102 ++++++++++
 tb/tb_sdf_issue_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/raymarch_pkg.sv
// Shared float/point types for the raymarching core.
// Points travel as packed {z,y,x} 27-bit floats.
package raymarch_pkg;
  localparam int FP_W = 27;
  typedef logic [FP_W-1:0] fp_t;
  typedef struct packed { fp_t z; fp_t y; fp_t x; } point_t;
  localparam fp_t FP_ZERO    = 27'h0000000;
  localparam fp_t FP_ONE     = 27'h1fc0000;
  localparam fp_t FP_NEG_ONE = 27'h5fc0000;
endpackage

// File: rtl/sdf_result_fifo.sv
// Result FIFO holding {id, distance} pairs between the SDF pipe and the consumer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sdf_result_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push && !o_full)  r_wr <= r_wr + 1'b1;
      if (i_pop  && !o_empty) r_rd <= r_rd + 1'b1;
    end

  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_wr[AW-1:0]] <= i_din;

  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  // Head reads as zero while empty so outputs stay clean out of reset.
  assign o_dout  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/sdf_issue_arbiter.sv
// Round-robin issue of requester points into a fixed-latency SDF evaluator,
// with an id tag pipe and a credit-protected result FIFO on the return path.
module sdf_issue_arbiter
  import raymarch_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int SDF_STAGES = 2,
  parameter  int FIFO_DEPTH = 8,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0][3*FP_W-1:0] i_req_point,
  output fp_t                           o_sdf_x,
  output fp_t                           o_sdf_y,
  output fp_t                           o_sdf_z,
  input  fp_t                           i_sdf_distance,
  output logic                          o_resp_valid,
  input  logic                          i_resp_ready,
  output logic [IDW-1:0]                o_resp_id,
  output fp_t                           o_resp_distance
);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  logic [CW-1:0]                 r_credits, w_credits_eff;
  logic [IDW-1:0]                r_rr_ptr, w_gnt;
  logic                          w_found, w_issue, w_pop;
  logic [SDF_STAGES:0]           r_v_pipe;
  logic [SDF_STAGES:0][IDW-1:0]  r_id_pipe;
  point_t                        w_pt;
  logic                          w_empty, w_full;
  logic [$clog2(FIFO_DEPTH):0]   w_count;
  logic [IDW+FP_W-1:0]           w_dout;

  // First valid requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDW:0] v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_idx >= (IDW+1)'(NUM_REQ)) v_idx = v_idx - (IDW+1)'(NUM_REQ);
      if (!w_found && i_req_valid[v_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_idx[IDW-1:0];
      end
    end
  end

  // A same-cycle pop frees a slot immediately; no credits at all while in reset.
  assign w_pop         = o_resp_valid & i_resp_ready;
  assign w_credits_eff = rst_n ? r_credits + CW'(w_pop) : '0;
  assign w_issue       = w_found && (w_credits_eff != '0);
  assign o_req_ready   = w_issue ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_pt          = i_req_point[w_gnt];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_credits <= CW'(FIFO_DEPTH);
      r_v_pipe  <= '0;
      r_id_pipe <= '0;
      o_sdf_x   <= '0;
      o_sdf_y   <= '0;
      o_sdf_z   <= '0;
    end else begin
      r_v_pipe  <= {r_v_pipe[SDF_STAGES-1:0], w_issue};
      r_id_pipe <= {r_id_pipe[SDF_STAGES-1:0], w_gnt};
      if (w_issue && !w_pop)      r_credits <= r_credits - 1'b1;
      else if (!w_issue && w_pop) r_credits <= r_credits + 1'b1;
      if (w_issue) begin
        r_rr_ptr <= (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        o_sdf_x  <= w_pt.x;
        o_sdf_y  <= w_pt.y;
        o_sdf_z  <= w_pt.z;
      end
    end

  sdf_result_fifo #(.W(IDW + FP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_v_pipe[SDF_STAGES]),
    .i_din   ({r_id_pipe[SDF_STAGES], i_sdf_distance}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign o_resp_valid                 = !w_empty;
  assign {o_resp_id, o_resp_distance} = w_dout;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_v_pipe[SDF_STAGES] && w_full));

  a_credit_sum: assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_credits) + int'(w_count) + $countones(r_v_pipe) == FIFO_DEPTH);
endmodule

// File: tb/tb_sdf_issue_arbiter.sv
// Randomized bench for sdf_issue_arbiter against an outstanding-request queue model;
// the SDF is a delay line returning sdf_x, so each response must carry its requester's x.
module tb_sdf_issue_arbiter;
  import raymarch_pkg::*;
  localparam int N = 4, S = 2, D = 8, IDW = 2;

  logic                      clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]              req_valid = '0, req_ready;
  logic [N-1:0][3*FP_W-1:0]  req_point = '0;
  fp_t                       sdf_x, sdf_y, sdf_z, sdf_dist;
  logic                      resp_valid, resp_ready = 1'b0;
  logic [IDW-1:0]            resp_id;
  fp_t                       resp_dist;
  fp_t                       dl [S];

  sdf_issue_arbiter #(.NUM_REQ(N), .SDF_STAGES(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_point(req_point),
    .o_sdf_x(sdf_x), .o_sdf_y(sdf_y), .o_sdf_z(sdf_z), .i_sdf_distance(sdf_dist),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_id(resp_id), .o_resp_distance(resp_dist)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl[0] <= sdf_x;
    for (int i = 1; i < S; i++) dl[i] <= dl[i-1];
  end
  assign sdf_dist = dl[S-1];

  typedef struct { int id; fp_t x; int t; } exp_t;
  exp_t q[$];
  int   rr = 0, cyc = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic rand_pts();
    for (int i = 0; i < N; i++)
      req_point[i] = {fp_t'($urandom), fp_t'($urandom), fp_t'($urandom)};
  endtask

  // One cycle: drive, check at negedge against the model, advance the model.
  task automatic step(input logic [N-1:0] v, input logic rdy);
    int g, cred;
    bit found, pop, exp_rv;
    logic [N-1:0] exp_rdy;
    req_valid  = v;
    resp_ready = rdy;
    @(negedge clk);
    exp_rv = (q.size() > 0) && (cyc >= q[0].t + S + 2);
    chk("resp_valid", resp_valid, exp_rv);
    if (exp_rv) begin
      chk("resp_id", resp_id, q[0].id);
      chk("resp_dist", resp_dist, q[0].x);
    end
    pop  = exp_rv && rdy;
    cred = D - q.size() + int'(pop);
    found = 0; g = 0;
    for (int k = 0; k < N; k++)
      if (!found && v[(rr + k) % N]) begin found = 1; g = (rr + k) % N; end
    exp_rdy = (found && cred > 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    if (pop) void'(q.pop_front());
    if (found && cred > 0) begin
      q.push_back('{g, fp_t'(req_point[g][FP_W-1:0]), cyc});
      rr = (g + 1) % N;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_id"}, resp_id, '0);
    chk({tag, "_resp_dist"}, resp_dist, '0);
    chk({tag, "_sdf_xyz"}, {sdf_z, sdf_y, sdf_x}, '0);
  endtask

  int bias;

  initial begin
    // Reset state with every requester asking.
    req_valid = '1;
    rand_pts();
    #12 reset_checks("rst");
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; cyc++;

    // Single request from requester 2, x = 1.0.
    req_point[2] = {FP_ZERO, FP_NEG_ONE, FP_ONE};
    step(4'b0100, 1'b1);
    chk("sdf_x", sdf_x, FP_ONE);
    chk("sdf_y", sdf_y, FP_NEG_ONE);
    repeat (6) step('0, 1'b1);

    // All valid, consumer keeping up: strict rotation.
    for (int i = 0; i < 12; i++) begin rand_pts(); step('1, 1'b1); end
    repeat (8) step('0, 1'b1);

    // Consumer stalled: only FIFO_DEPTH accepted, then a single pop re-grants.
    for (int i = 0; i < 14; i++) begin rand_pts(); step('1, 1'b0); end
    step('1, 1'b1);
    repeat (3) step('1, 1'b0);
    repeat (14) step('0, 1'b1);

    // Round-robin pointer across valid drops.
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b0010, 1'b1);
    repeat (8) step('0, 1'b1);

    // Reset with three in flight and two queued.
    for (int i = 0; i < 5; i++) begin rand_pts(); step('1, 1'b0); end
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    q.delete();
    rr = 0;
    repeat (2) begin
      @(negedge clk); chk("midrst_hold_ready", req_ready, '0);
      @(posedge clk); #1; cyc++;
    end
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; cyc++;
    repeat (6) step('0, 1'b1);
    for (int i = 0; i < 11; i++) begin rand_pts(); step('1, 1'b0); end
    repeat (14) step('0, 1'b1);

    // Random traffic with varying back-pressure.
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 3)
        0: bias = 95;
        1: bias = 60;
        default: bias = 20;
      endcase
      rand_pts();
      step(N'($urandom), $urandom_range(0, 99) < bias);
    end
    repeat (20) step('0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
